lfsr_interval_timer: RTL
========================

Name: lfsr_interval_timer

Overview:
Parametrised LFSR-based interval timer. It is the general-purpose successor to the fixed 16-bit, fixed-terminal 1 ms pulse counter. Width, feedback taps and seed are parameters. The terminal state is a run-time input, latched at start. The block adds one-shot/periodic modes, count enable, abort, and busy/done status. It sits beside the trainer's sequencing FSMs and produces ms/character timing ticks from the system clock without a binary adder.

Parameters:
WIDTH, 16, LFSR and terminal-value width (>=3).
TAPS, 16'h002D, Galois feedback mask XORed into the shifted register when MSB=1 (bit0 included).
SEED, all-ones, load value at start/reload; must be nonzero.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; synchronous, active-low
start  in  1  1-cycle request: latch term, load SEED, enter RUN
stop  in  1  abort run, return to IDLE without tick
en  in  1  count enable; 0 freezes LFSR in RUN
mode  in  1  0 = periodic, 1 = one-shot; sampled with start
term  in  WIDTH  LFSR state that triggers a tick; sampled with start
tick  out  1  registered 1-cycle pulse at interval end
busy  out  1  1 while in RUN
done  out  1  sticky one-shot completion flag
lfsr_q  out  WIDTH  current LFSR state, for debug/bench

Behaviour:
- Next-state function: nxt = {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? TAPS : 0).
- Reset (rst=0 at edge): state=IDLE, lfsr=SEED, term_q=0, mode_q=0, tick=0, busy=0, done=0. Reset overrides all inputs.
- States: IDLE, RUN. tick defaults to 0 every cycle; it is 1 only on the cycle after a match edge.
- IDLE:
  - start=1 and stop=0 -> lfsr=SEED, term_q=term, mode_q=mode, done=0, busy=1, go to RUN.
  - en is ignored in IDLE.
- RUN, evaluated in priority order at each edge:
  1. stop=1 -> IDLE, busy=0, no tick, done unchanged.
  2. start=1 -> restart: reload SEED, relatch term/mode. No tick that cycle, even if lfsr==term_q.
  3. en=0 -> hold lfsr, tick=0.
  4. lfsr==term_q -> tick=1.
     - Periodic: lfsr=SEED, stay in RUN.
     - One-shot: go to IDLE, busy=0, done=1, lfsr=SEED.
  5. Otherwise -> lfsr=nxt.
- Interval: let d = number of nxt steps from SEED to term_q, counting only enabled cycles. First tick asserts d+1 enabled edges after the start edge. Thereafter ticks are every d+1 enabled cycles.
  - term_q==SEED gives d=0: tick every enabled cycle (periodic).
- Unreachable term (all-zeros, or a state outside the SEED cycle for a non-maximal TAPS): no tick ever, busy stays 1. This is legal; only stop or rst exits.
- stop and start asserted in the same IDLE cycle: stop wins, remain IDLE.
- term/mode changes during RUN have no effect until the next start.
- done clears only on accepted start or rst.
- No combinational path from any input to any output.

Test Plan:
1. WIDTH=4, TAPS=4'h3, SEED=4'hF, term=4'h1, mode=0, en=1, start pulse at edge 0 -> lfsr_q F,D,9,1,F,D...; tick high after edges 4, 8, 12; busy=1 throughout.
2. Same config with mode=1 -> single tick after edge 4; busy falls and done=1 after edge 4; lfsr_q=F; no further ticks.
3. term=4'hE, mode=0 -> ticks 15 cycles apart. term=4'hF -> tick every cycle. term=4'h0 -> no tick in 40 cycles, busy stays 1.
4. term=4'h1, en low for 3 cycles right after lfsr_q=D -> lfsr_q holds D; first tick delayed to edge 7.
5. Abort and restart:
   - stop at edge 2 -> IDLE, busy=0, no tick.
   - start at edge 3 of a run -> reload F; next tick 4 cycles later.
   - rst=0 mid-run -> all outputs zero, lfsr_q=F next cycle.
6. Default parameters (WIDTH=16, TAPS=16'h002D, SEED=16'hFFFF), term set to the state reached after 49999 steps -> tick period exactly 50000 cycles, checked against a bench reference model.

Source files
------------

// File: rtl/lfsr_interval_timer.sv
// LFSR-based interval timer.
//
// A Galois LFSR is loaded with SEED on start and stepped once per enabled cycle.
// When it reaches the terminal state latched at start, a one-cycle tick is issued
// on the following cycle. In periodic mode the LFSR reloads SEED and the run
// continues; in one-shot mode the run ends and done is set.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous, active-low reset
//   start  - begin or restart a run; latches term and mode
//   stop   - abort the run without a tick
//   en     - count enable; 0 freezes the LFSR while running
//   mode   - 0 = periodic, 1 = one-shot (sampled with start)
//   term   - LFSR state that ends an interval (sampled with start)
//   tick   - registered 1-cycle pulse at interval end
//   busy   - high while a run is active
//   done   - sticky one-shot completion flag, cleared by start or reset
//   lfsr_q - current LFSR state
module lfsr_interval_timer #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(16'h002D),
  parameter logic [WIDTH-1:0]     SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lfsr_q
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lfsr_nxt;

  // Galois step: shift left, fold the taps in when the bit shifted out was set.
  assign lfsr_nxt = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? TAPS : '0);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    term_d  = term_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StRun;
          lfsr_d  = SEED;
          term_d  = term;
          mode_d  = mode;
          done_d  = 1'b0;
        end
      end
      StRun: begin
        if (stop) begin
          // Abort leaves the LFSR where it was; the next start reloads SEED.
          state_d = StIdle;
        end else if (start) begin
          // Restart never ticks, even when the current state matches.
          lfsr_d = SEED;
          term_d = term;
          mode_d = mode;
        end else if (en) begin
          if (lfsr_q == term_q) begin
            tick_d = 1'b1;
            lfsr_d = SEED;
            if (mode_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            lfsr_d = lfsr_nxt;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      term_q  <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // All outputs come straight from registers.
  assign tick = tick_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule
